// File: rtl/rand_index_sel_pkg.sv
// Shared constants for the candidate-selection engine.
// Holds the move-count limit, the index/count widths and the FSM state
// encoding used by rand_index_sel.
package rand_index_sel_pkg;

  localparam int MAX_MOVE_COUNT = 256;
  localparam int IDX_W          = 8;   // index range 0..255
  localparam int CNT_W          = 9;   // count range 0..256
  localparam int SLICES         = 4;   // 8-bit slices tried per random word

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_DONE   = 2'd2
  } sel_state_t;

endpackage

// File: rtl/rand_index_sel_mask.sv
// rand_mask_gen: combinational mask generator.
// Produces the smallest (2^k - 1) that covers count-1, so a masked random
// byte lands in [0, 2*count) and rejection sampling keeps its odds above 1/2.
// Ports:
//   i_count [8:0] : number of candidates, 0..256
//   o_mask  [7:0] : covering mask (0 for count 0 or 1)
module rand_mask_gen
  import rand_index_sel_pkg::*;
(
  input  logic [CNT_W-1:0] i_count,
  output logic [IDX_W-1:0] o_mask
);

  logic [IDX_W-1:0] w_m;
  logic [IDX_W-1:0] w_s;

  always_comb begin
    // 8-bit subtraction: count 256 wraps to 255, which is the wanted value.
    w_m = i_count[IDX_W-1:0] - 8'd1;
    // Smear the highest set bit downwards.
    w_s = w_m;
    w_s = w_s | (w_s >> 1);
    w_s = w_s | (w_s >> 2);
    w_s = w_s | (w_s >> 4);
    o_mask = (i_count == '0) ? '0 : w_s;
  end

endmodule

// File: rtl/rand_index_sel.sv
// rand_index_sel: maps a free-running 32-bit random word to an unbiased
// index in [0, count) by rejection sampling. Four masked byte slices are
// tried per cycle; after MAX_WORDS fully rejected words a deterministic
// fallback folds slice 0 back into range.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   rand_in [31:0]    : random word, used only while sampling
//   req_valid/ready   : request handshake, req_count [8:0] = 0..256
//   idx_valid/ready   : result handshake, result held until accepted
//   idx [7:0]         : selected index
//   idx_err           : request had count 0 (idx = 0)
//   idx_fallback      : result came from the fallback path
module rand_index_sel
  import rand_index_sel_pkg::*;
#(
  parameter int MAX_WORDS = 4   // legal 1..15
)(
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      rand_in,
  input  logic             req_valid,
  input  logic [CNT_W-1:0] req_count,
  output logic             req_ready,
  output logic             idx_valid,
  output logic [IDX_W-1:0] idx,
  output logic             idx_err,
  output logic             idx_fallback,
  input  logic             idx_ready
);

  localparam logic [3:0] LAST_WORD = 4'(MAX_WORDS - 1);

  sel_state_t       r_state;
  logic [CNT_W-1:0] r_count;
  logic [IDX_W-1:0] r_mask;
  logic [3:0]       r_attempt;
  logic             r_valid;
  logic [IDX_W-1:0] r_idx;
  logic             r_err;
  logic             r_fb;

  logic [IDX_W-1:0]              w_req_mask;
  logic [SLICES-1:0][IDX_W-1:0]  w_slice;
  logic [SLICES-1:0]             w_hit;
  logic                          w_any;
  logic [IDX_W-1:0]              w_sel;
  logic [IDX_W-1:0]              w_fb_idx;

  rand_mask_gen u_mask (
    .i_count (req_count),
    .o_mask  (w_req_mask)
  );

  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    for (int i = 0; i < SLICES; i++) begin
      w_slice[i] = rand_in[8*i +: 8] & r_mask;
      // Zero-extend so count 256 accepts every slice.
      w_hit[i]   = {1'b0, w_slice[i]} < r_count;
    end
    // Scan high to low so the lowest accepted slice wins.
    for (int i = SLICES - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_any = 1'b1;
        w_sel = w_slice[i];
      end
    end
    // slice_0 >= count > (mask+1)/2 whenever this is used, so it stays in range.
    w_fb_idx = w_slice[0] - ((r_mask >> 1) + 8'd1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_mask    <= '0;
      r_attempt <= '0;
      r_valid   <= 1'b0;
      r_idx     <= '0;
      r_err     <= 1'b0;
      r_fb      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_count   <= req_count;
            r_mask    <= w_req_mask;
            r_attempt <= '0;
            if (req_count == 9'd0) begin
              r_idx   <= '0;
              r_err   <= 1'b1;
              r_valid <= 1'b1;
              r_state <= ST_DONE;
            end else if (req_count == 9'd1) begin
              r_idx   <= '0;
              r_valid <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_SAMPLE;
            end
          end
        end
        ST_SAMPLE: begin
          if (w_any) begin
            r_idx   <= w_sel;
            r_valid <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_attempt <= r_attempt + 4'd1;
            if (r_attempt == LAST_WORD) begin
              r_idx   <= w_fb_idx;
              r_fb    <= 1'b1;
              r_valid <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (idx_ready) begin
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_err   <= 1'b0;
            r_fb    <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready    = (r_state == ST_IDLE);
  assign idx_valid    = r_valid;
  assign idx          = r_idx;
  assign idx_err      = r_err;
  assign idx_fallback = r_fb;

endmodule

// File: tb/tb_rand_index_sel.sv
module tb_rand_index_sel;

  typedef struct packed {
    logic [7:0] idx;
    logic       err;
    logic       fb;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] rand_in;
  logic        req_valid;
  logic [8:0]  req_count;
  logic        req_ready;
  logic        idx_valid;
  logic [7:0]  idx;
  logic        idx_err;
  logic        idx_fallback;
  logic        idx_ready;

  int total = 0;
  int bad   = 0;
  exp_t sb_q[$];

  // Two words before fallback keeps the fallback case short.
  rand_index_sel #(.MAX_WORDS(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .rand_in      (rand_in),
    .req_valid    (req_valid),
    .req_count    (req_count),
    .req_ready    (req_ready),
    .idx_valid    (idx_valid),
    .idx          (idx),
    .idx_err      (idx_err),
    .idx_fallback (idx_fallback),
    .idx_ready    (idx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted result is compared against the scoreboard head.
  always @(negedge clk) begin
    if (!reset && idx_valid && idx_ready) begin
      if (sb_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_result: got idx=%0h with empty scoreboard", idx);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("res_idx", 32'(idx), 32'(e.idx));
        chk("res_err", 32'(idx_err), 32'(e.err));
        chk("res_fb",  32'(idx_fallback), 32'(e.fb));
      end
    end
  end

  // Called at posedge+1 while IDLE. Issues one request, feeds w0 on the first
  // SAMPLE cycle and w1 afterwards, and checks the request-to-valid latency.
  task automatic run(input string name, input logic [8:0] cnt,
                     input logic [31:0] w0, input logic [31:0] w1,
                     input int exp_lat, input logic [7:0] e_idx,
                     input logic e_err, input logic e_fb);
    int lat;
    exp_t e;
    e.idx = e_idx; e.err = e_err; e.fb = e_fb;
    sb_q.push_back(e);
    req_valid = 1'b1;
    req_count = cnt;
    rand_in   = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rand_in   = w0;
    lat = 1;
    forever begin
      @(negedge clk);
      if (idx_valid) break;
      if (lat > 20) begin
        total++; bad++;
        $display("FAIL %s_timeout: no idx_valid after %0d cycles", name, lat);
        break;
      end
      @(posedge clk); #1;
      lat++;
      rand_in = w1;
    end
    chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
    @(posedge clk); #1;
    chk({name, "_rdy_after"}, 32'(req_ready), 32'd1);
    chk({name, "_vld_after"}, 32'(idx_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; rand_in = '0; req_valid = 1'b0; req_count = '0; idx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(idx_valid), 32'd0);
    chk("rst_idx",   32'(idx), 32'd0);
    chk("rst_err",   32'(idx_err), 32'd0);
    chk("rst_fb",    32'(idx_fallback), 32'd0);
    chk("rst_rdy",   32'(req_ready), 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;

    // name, count, word0, word1, latency, idx, err, fb
    run("c5_first",  9'd5,   32'h0000_0003, 32'h0000_0003, 2, 8'd3,   1'b0, 1'b0);
    run("c5_slice3", 9'd5,   32'h0207_0506, 32'h0207_0506, 2, 8'd2,   1'b0, 1'b0);
    run("c5_fb",     9'd5,   32'h0707_0707, 32'h0707_0707, 3, 8'd3,   1'b0, 1'b1);
    run("c0_err",    9'd0,   32'h1234_5678, 32'h1234_5678, 1, 8'd0,   1'b1, 1'b0);
    run("c1",        9'd1,   32'h1234_5678, 32'h1234_5678, 1, 8'd0,   1'b0, 1'b0);
    run("c256",      9'd256, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2, 8'hEF,  1'b0, 1'b0);
    run("c2",        9'd2,   32'h0000_0001, 32'h0000_0001, 2, 8'd1,   1'b0, 1'b0);
    run("c3_fb",     9'd3,   32'h0303_0303, 32'h0303_0303, 3, 8'd1,   1'b0, 1'b1);
    run("c3_2nd",    9'd3,   32'hFFFF_FFFF, 32'h0000_0002, 3, 8'd2,   1'b0, 1'b0);
    run("c200_edge", 9'd200, 32'h05C8_C9FF, 32'h05C8_C9FF, 2, 8'd5,   1'b0, 1'b0);
    run("c200_max",  9'd200, 32'hC8C8_C8C7, 32'hC8C8_C8C7, 2, 8'd199, 1'b0, 1'b0);
    run("rand_zero", 9'd7,   32'h0000_0000, 32'h0000_0000, 2, 8'd0,   1'b0, 1'b0);

    // Back-pressure: result must hold while idx_ready is low; a second request is ignored.
    begin
      exp_t e;
      e.idx = 8'd1; e.err = 1'b0; e.fb = 1'b0;
      sb_q.push_back(e);
      idx_ready = 1'b0;
      req_valid = 1'b1; req_count = 9'd4; rand_in = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      req_valid = 1'b0; rand_in = 32'h0000_0001;
      @(posedge clk); #1;
      chk("stall_valid0", 32'(idx_valid), 32'd1);
      req_valid = 1'b1; req_count = 9'd0;
      for (int k = 0; k < 10; k++) begin
        @(posedge clk); #1;
        rand_in = 32'h0000_0003;
        chk("stall_valid", 32'(idx_valid), 32'd1);
        chk("stall_idx",   32'(idx), 32'd1);
        chk("stall_flags", 32'({idx_err, idx_fallback}), 32'd0);
        chk("stall_rdy",   32'(req_ready), 32'd0);
      end
      req_valid = 1'b0;
      idx_ready = 1'b1;
      @(posedge clk); #1;
      chk("stall_rel_rdy",   32'(req_ready), 32'd1);
      chk("stall_rel_valid", 32'(idx_valid), 32'd0);
      @(posedge clk); #1;
      chk("stall_no_extra",  32'(idx_valid), 32'd0);
    end

    // Reset while sampling discards the pending result.
    req_valid = 1'b1; req_count = 9'd5; rand_in = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    req_valid = 1'b0; rand_in = 32'h0707_0707;
    chk("mid_in_sample", 32'(req_ready), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_valid", 32'(idx_valid), 32'd0);
    chk("mid_rst_rdy",   32'(req_ready), 32'd1);
    chk("mid_rst_fb",    32'(idx_fallback), 32'd0);
    run("post_rst", 9'd4, 32'h0000_0002, 32'h0000_0002, 2, 8'd2, 1'b0, 1'b0);

    @(posedge clk); #1;
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
